// File: rtl/riscv_mem_pkg.sv
// Shared constants for the core's memory-side responder.
// MMIO offsets are word indices taken from Adr[5:2].
package riscv_mem_pkg;

   localparam logic [3:0] OFF_GPIO_OUT   = 4'h0;
   localparam logic [3:0] OFF_GPIO_IN    = 4'h1;
   localparam logic [3:0] OFF_CYCLE      = 4'h2;
   localparam logic [3:0] OFF_TIMER_CNT  = 4'h3;
   localparam logic [3:0] OFF_TIMER_CMP  = 4'h4;
   localparam logic [3:0] OFF_TIMER_CTRL = 4'h5;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AR   = 1;
   localparam int CTRL_IE   = 2;
   localparam int CTRL_FLAG = 3;

   localparam logic [31:0] CMP_RST     = 32'hFFFF_FFFF;
   localparam logic [31:0] UNMAPPED_RD = 32'h0;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Single-port core memory bus: the core is master, memory is slave.
// Data_in is combinational from Adr on the slave side.
interface riscv_mem_if;

   logic [31:0] Adr;
   logic        MemWrite;
   logic [31:0] Data_out;
   logic [31:0] Data_in;

   modport master (
      output Adr, MemWrite, Data_out,
      input  Data_in
   );

   modport slave (
      input  Adr, MemWrite, Data_out,
      output Data_in
   );

endinterface

// File: rtl/riscv_mem_responder_mmio_timer.sv
// Compare timer: CNT/CMP/CTRL registers, match flag and level irq.
// Instantiated only when RISCV_MEM_TIMER_EN is defined.
module mmio_timer
   import riscv_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic [3:0]  off,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [31:0] cnt;
   logic [31:0] cmp;
   logic [2:0]  ctrl;
   logic        flag;
   logic        match;
   logic        wr_cnt;
   logic        wr_cmp;
   logic        wr_ctrl;

   assign wr_cnt  = wr && (off == OFF_TIMER_CNT);
   assign wr_cmp  = wr && (off == OFF_TIMER_CMP);
   assign wr_ctrl = wr && (off == OFF_TIMER_CTRL);
   assign match   = ctrl[CTRL_EN] && (cnt == cmp);
   assign irq     = flag & ctrl[CTRL_IE];

   // Bus write to CNT beats increment/reload; match-set beats W1C.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         cmp  <= CMP_RST;
         ctrl <= '0;
         flag <= 1'b0;
      end else begin
         if (wr_cnt)
            cnt <= wdata;
         else if (ctrl[CTRL_EN])
            cnt <= (match && ctrl[CTRL_AR]) ? '0 : cnt + 32'd1;
         if (wr_cmp)
            cmp <= wdata;
         if (wr_ctrl)
            ctrl <= wdata[CTRL_IE:CTRL_EN];
         if (match)
            flag <= 1'b1;
         else if (wr_ctrl && wdata[CTRL_FLAG])
            flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_TIMER_CNT:  rdata = cnt;
         OFF_TIMER_CMP:  rdata = cmp;
         OFF_TIMER_CTRL: rdata = {28'd0, flag, ctrl};
         default:        rdata = '0;
      endcase
   end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder: unified RAM plus GPIO/cycle/timer MMIO.
// Timer block is present only when RISCV_MEM_TIMER_EN is defined.
module riscv_mem_responder
   import riscv_mem_pkg::*;
#(
   parameter int          MEM_ADDR_W = 10,
   parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
   parameter int          GPIO_W     = 8,
   parameter string       INIT_FILE  = ""
) (
   input  logic              clk,
   input  logic              rst,
   riscv_mem_if.slave        bus,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq_timer,
   output logic              bus_err
);

   localparam int RAM_WORDS = 1 << MEM_ADDR_W;

   logic [31:0]           mem [RAM_WORDS];
   logic                  ram_sel;
   logic                  mmio_sel;
   logic                  mmio_wr;
   logic [3:0]            off;
   logic [MEM_ADDR_W-1:0] idx;
   logic [GPIO_W-1:0]     gpio_meta;
   logic [GPIO_W-1:0]     gpio_sync;
   logic [31:0]           cycle;
   logic [31:0]           tmr_rdata;
   logic [31:0]           rdata;

   assign ram_sel  = (bus.Adr[31:MEM_ADDR_W+2] == '0);
   assign mmio_sel = (bus.Adr[31:6] == MMIO_BASE[31:6]);
   assign mmio_wr  = bus.MemWrite && mmio_sel;
   assign off      = bus.Adr[5:2];
   assign idx      = bus.Adr[MEM_ADDR_W+1:2];

   // RAM survives reset.
   always_ff @(posedge clk) begin
      if (bus.MemWrite && ram_sel)
         mem[idx] <= bus.Data_out;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpio_out  <= '0;
         gpio_meta <= '0;
         gpio_sync <= '0;
         cycle     <= '0;
         bus_err   <= 1'b0;
      end else begin
         gpio_meta <= gpio_in;
         gpio_sync <= gpio_meta;
         cycle     <= cycle + 32'd1;
         if (mmio_wr && (off == OFF_GPIO_OUT))
            gpio_out <= bus.Data_out[GPIO_W-1:0];
         if (bus.MemWrite && !ram_sel && !mmio_sel)
            bus_err <= 1'b1;
      end
   end

`ifdef RISCV_MEM_TIMER_EN
   mmio_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .wr    (mmio_wr),
      .off   (off),
      .wdata (bus.Data_out),
      .rdata (tmr_rdata),
      .irq   (irq_timer)
   );

   logic unused_adr;
   assign unused_adr = ^bus.Adr[1:0];
`else
   assign tmr_rdata = '0;
   assign irq_timer = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{bus.Adr[1:0], bus.Data_out[31:GPIO_W]};
`endif

   always_comb begin
      rdata = UNMAPPED_RD;
      unique case (1'b1)
         ram_sel: rdata = mem[idx];
         mmio_sel: begin
            case (off)
               OFF_GPIO_OUT:   rdata = 32'(gpio_out);
               OFF_GPIO_IN:    rdata = 32'(gpio_sync);
               OFF_CYCLE:      rdata = cycle;
               OFF_TIMER_CNT,
               OFF_TIMER_CMP,
               OFF_TIMER_CTRL: rdata = tmr_rdata;
               default:        rdata = '0;
            endcase
         end
         default: rdata = UNMAPPED_RD;
      endcase
   end

   assign bus.Data_in = rdata;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed bench for riscv_mem_responder (RAM, GPIO, cycle, timer, errors).
module tb_riscv_mem_responder;
   import riscv_mem_pkg::*;

   localparam logic [31:0] MB = 32'h1000_0000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq_timer;
   logic       bus_err;
   int         n_vec = 0;
   int         n_err = 0;

   riscv_mem_if bus ();

   riscv_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .irq_timer (irq_timer),
      .bus_err   (bus_err)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.Adr      = a;
      bus.Data_out = d;
      bus.MemWrite = 1'b1;
      tick();
      bus.MemWrite = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
      bus.Adr = a;
      #1;
      chk(tag, bus.Data_in, exp);
   endtask

   initial begin
      bus.Adr      = '0;
      bus.MemWrite = 1'b0;
      bus.Data_out = '0;
      gpio_in      = '0;
      tick(2);
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      chk("rst_irq", 32'(irq_timer), 32'h0);
      rst = 1'b1;
      rd("cycle0", MB + 32'h8, 32'd0);
      tick(3);
      rd("cycle3", MB + 32'h8, 32'd3);
      rd("gpio_in_rst", MB + 32'h4, 32'h0);
`ifdef RISCV_MEM_TIMER_EN
      rd("cmp_rst", MB + 32'h10, CMP_RST);
      rd("cnt_rst", MB + 32'hC, 32'h0);
`endif

      // RAM: old data during write cycle, new data after the edge
      wr(32'h10, 32'h1111_1111);
      bus.Adr      = 32'h10;
      bus.Data_out = 32'hCAFE_0001;
      bus.MemWrite = 1'b1;
      #1;
      chk("ram_old", bus.Data_in, 32'h1111_1111);
      tick();
      bus.MemWrite = 1'b0;
      rd("ram_new", 32'h10, 32'hCAFE_0001);
      wr(32'hFFC, 32'h5555_AAAA);
      rd("ram_top", 32'hFFC, 32'h5555_AAAA);
      rd("ram_keep", 32'h10, 32'hCAFE_0001);
      rd("ram_lowbits", 32'h13, 32'hCAFE_0001);
      rd("above_ram", 32'h1000, 32'h0);

      wr(MB, 32'h0000_00A5);
      chk("gpio_out_a5", 32'(gpio_out), 32'hA5);
      rd("gpio_rd_a5", MB, 32'hA5);
      wr(MB, 32'hFFFF_FF5A);
      chk("gpio_out_5a", 32'(gpio_out), 32'h5A);
      rd("gpio_rd_5a", MB, 32'h5A);
      gpio_in = 8'h3C;
      rd("gpio_in_e0", MB + 32'h4, 32'h0);
      tick();
      rd("gpio_in_e1", MB + 32'h4, 32'h0);
      tick();
      rd("gpio_in_e2", MB + 32'h4, 32'h3C);

      wr(MB + 32'h3C, 32'hFFFF_FFFF);
      rd("mmio_hole", MB + 32'h3C, 32'h0);
      chk("hole_no_err", 32'(bus_err), 32'h0);

`ifdef RISCV_MEM_TIMER_EN
      wr(MB + 32'h10, 32'd5);
      wr(MB + 32'hC, 32'd0);
      wr(MB + 32'h14, 32'h7);
      rd("cnt_start", MB + 32'hC, 32'd0);
      tick(5);
      rd("cnt_match", MB + 32'hC, 32'd5);
      rd("ctrl_pre", MB + 32'h14, 32'h7);
      chk("irq_pre", 32'(irq_timer), 32'h0);
      tick();
      rd("cnt_reload", MB + 32'hC, 32'd0);
      rd("ctrl_flag", MB + 32'h14, 32'hF);
      chk("irq_set", 32'(irq_timer), 32'h1);
      tick();
      rd("cnt_after", MB + 32'hC, 32'd1);
      wr(MB + 32'h14, 32'hF);
      rd("ctrl_w1c", MB + 32'h14, 32'h7);
      chk("irq_clr", 32'(irq_timer), 32'h0);
      tick(3);
      rd("cnt_match2", MB + 32'hC, 32'd5);
      wr(MB + 32'h14, 32'hF);
      rd("set_wins", MB + 32'h14, 32'hF);
      rd("cnt_reload2", MB + 32'hC, 32'd0);
      wr(MB + 32'hC, 32'd100);
      rd("cnt_wr", MB + 32'hC, 32'd100);
      tick();
      rd("cnt_wr_inc", MB + 32'hC, 32'd101);
      wr(MB + 32'h14, 32'h0);
      rd("cnt_dis", MB + 32'hC, 32'd102);
      tick();
      rd("cnt_hold", MB + 32'hC, 32'd102);
      rd("ctrl_dis", MB + 32'h14, 32'h8);
      chk("irq_ie0", 32'(irq_timer), 32'h0);
`else
      wr(MB + 32'hC, 32'd1234);
      rd("tmr_off_cnt", MB + 32'hC, 32'h0);
      wr(MB + 32'h14, 32'h7);
      rd("tmr_off_ctrl", MB + 32'h14, 32'h0);
      chk("tmr_off_irq", 32'(irq_timer), 32'h0);
      chk("tmr_off_err", 32'(bus_err), 32'h0);
`endif

      wr(32'h2000_0000, 32'hDEAD_BEEF);
      chk("bus_err_set", 32'(bus_err), 32'h1);
      rd("unmapped_rd", 32'h2000_0000, 32'h0);
      rd("unmapped_ram", 32'h10, 32'hCAFE_0001);
      chk("unmapped_gpio", 32'(gpio_out), 32'h5A);
      tick(2);
      chk("bus_err_hold", 32'(bus_err), 32'h1);

`ifdef RISCV_MEM_TIMER_EN
      wr(MB + 32'hC, 32'd37);
      wr(MB + 32'h14, 32'h5);
      rd("cnt_pre_rst", MB + 32'hC, 32'd37);
      chk("irq_pre_rst", 32'(irq_timer), 32'h1);
`endif
      rst = 1'b0;
      #1;
      chk("mid_gpio_out", 32'(gpio_out), 32'h0);
      chk("mid_bus_err", 32'(bus_err), 32'h0);
      chk("mid_irq", 32'(irq_timer), 32'h0);
      rd("mid_cycle", MB + 32'h8, 32'h0);
      rd("mid_gpio_in", MB + 32'h4, 32'h0);
`ifdef RISCV_MEM_TIMER_EN
      rd("mid_cnt", MB + 32'hC, 32'h0);
      rd("mid_cmp", MB + 32'h10, CMP_RST);
      rd("mid_ctrl", MB + 32'h14, 32'h0);
`endif
      rst = 1'b1;
      rd("ram_kept", 32'h10, 32'hCAFE_0001);
      rd("ram_top_kept", 32'hFFC, 32'h5555_AAAA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
